// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter's input FIFO.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes are queued in a small FIFO and shifted out LSB first,
// with bit timing derived from a clock-enable counter in the single clk domain.
module uart_tx #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy,
  output logic     done
);

  localparam int CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bit_end;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign bus.tx_ready = !full;
  assign push         = bus.tx_valid && !full;
  assign bit_end      = (bit_cnt == LAST_CNT);
  assign head         = mem[rd_ptr];

  // A byte leaves the FIFO either from IDLE or on the last cycle of a stop bit,
  // so consecutive frames follow each other without an idle cycle.
  assign pop = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Storage is intentionally not reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (pop) begin
            shreg <= head;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        // shreg[0] is always the bit currently on the line.
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            done    <= 1'b1;
            if (pop) begin
              shreg <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level table vectors, corner-case sequences
// and random bytes scored by a line-decoding receiver model.
module tb_uart_tx;

  localparam int C_MAIN = 1000000 / 9600;
  localparam int C_P5   = 50 / 10;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  logic clk;
  logic rst;
  logic tx, busy, done;
  logic tx5, busy5, done5;
  int   cyc;
  int   n_compared;
  int   n_mismatched;
  int   frames_seen;
  logic [7:0] exp_q[$];
  logic [7:0] mon_byte;
  bit         mon_abort;

  uart_tx_if bus();
  uart_tx_if bus5();

  uart_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx),
    .busy(busy),
    .done(done)
  );

  uart_tx #(.clk_freq(50), .baud_rate(10), .FIFO_DEPTH(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5),
    .tx  (tx5),
    .busy(busy5),
    .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every handshake the main DUT accepts becomes a byte expected on the line.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.tx_valid && bus.tx_ready) exp_q.push_back(bus.tx_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic sel_tx(input bit s);
    return s ? tx5 : tx;
  endfunction

  function automatic logic sel_busy(input bit s);
    return s ? busy5 : busy;
  endfunction

  function automatic logic sel_done(input bit s);
    return s ? done5 : done;
  endfunction

  function automatic logic sel_ready(input bit s);
    return s ? bus5.tx_ready : bus.tx_ready;
  endfunction

  task automatic drive_bus(input bit s, input logic v, input logic [7:0] d);
    if (s) begin
      bus5.tx_valid = v;
      bus5.tx_data  = d;
    end else begin
      bus.tx_valid = v;
      bus.tx_data  = d;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic applyStimulus(input bit s, input logic [7:0] d);
    int waited;
    waited = 0;
    drive_bus(s, 1'b1, d);
    #1;
    while (!sel_ready(s) && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!sel_ready(s)) checkOutput("accept_timeout", 32'(sel_ready(s)), 1);
    @(negedge clk);
  endtask

  task automatic release_bus(input bit s);
    drive_bus(s, 1'b0, 8'h00);
  endtask

  // Cycle-exact frame check: every bit level must last exactly c cycles.
  task automatic check_frame(input string name, input bit s, input int c, input logic [9:0] frame,
                             input bit last, input int exp_wait);
    int waited;
    int good;
    int busy_low;
    int done_extra;
    waited     = 0;
    busy_low   = 0;
    done_extra = 0;
    while (sel_tx(s) !== 1'b0 && waited < 20 * c + 20) begin
      @(negedge clk);
      waited++;
    end
    if (sel_tx(s) !== 1'b0) begin
      checkOutput({name, "_fall_timeout"}, 32'(sel_tx(s)), 0);
      return;
    end
    if (exp_wait >= 0) checkOutput({name, "_latency"}, waited, exp_wait);
    for (int b = 0; b < 10; b++) begin
      good = 0;
      for (int k = 0; k < c; k++) begin
        if (sel_tx(s) === frame[b]) good++;
        if (sel_busy(s) !== 1'b1) busy_low++;
        if ((b != 0 || k != 0) && sel_done(s) !== 1'b0) done_extra++;
        @(negedge clk);
      end
      checkOutput($sformatf("%s_bit%0d_len", name, b), good, c);
    end
    checkOutput({name, "_busy_held"}, busy_low, 0);
    checkOutput({name, "_done_quiet"}, done_extra, 0);
    checkOutput({name, "_done_pulse"}, 32'(sel_done(s)), 1);
    if (last) begin
      checkOutput({name, "_busy_end"}, 32'(sel_busy(s)), 0);
      checkOutput({name, "_tx_idle"}, 32'(sel_tx(s)), 1);
      @(negedge clk);
      checkOutput({name, "_done_once"}, 32'(sel_done(s)), 0);
    end else begin
      checkOutput({name, "_busy_stay"}, 32'(sel_busy(s)), 1);
      checkOutput({name, "_next_start"}, 32'(sel_tx(s)), 0);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 12000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drain_busy"}, 32'(busy), 0);
    checkOutput({name, "_drain_queue"}, exp_q.size(), 0);
  endtask

  task automatic mon_wait(input int n, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) aborted = 1'b1;
    end
  endtask

  // Reference receiver: mid-bit sampling of the main line, scored against accepted bytes.
  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_wait(C_MAIN / 2, mon_abort);
        if (!mon_abort) checkOutput("mon_start", 32'(tx), 0);
        for (int i = 0; i < 8 && !mon_abort; i++) begin
          mon_wait(C_MAIN, mon_abort);
          mon_byte[i] = tx;
        end
        if (!mon_abort) mon_wait(C_MAIN, mon_abort);
        if (!mon_abort) begin
          checkOutput("mon_stop", 32'(tx), 1);
          frames_seen++;
          if (exp_q.size() == 0) checkOutput("mon_unexpected_frame", exp_q.size(), 1);
          else checkOutput("mon_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs[4];
    int   fs0;
    int   first_cyc;
    int   waited;
    int   bad;
    int   n_rand;

    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h81, frame: 10'b1100000010};

    n_compared   = 0;
    n_mismatched = 0;
    frames_seen  = 0;
    cyc          = 0;
    rst          = 1'b0;
    release_bus(0);
    release_bus(1);

    #2 rst = 1'b1;
    #1;
    checkOutput("reset_tx", 32'(tx), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_ready", 32'(bus.tx_ready), 1);
    checkOutput("reset_tx_p5", 32'(tx5), 1);
    checkOutput("reset_ready_p5", 32'(bus5.tx_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-byte table vectors");
    for (int v = 0; v < 4; v++) begin
      applyStimulus(0, vecs[v].data);
      release_bus(0);
      check_frame($sformatf("vec%0d", v), 0, C_MAIN, vecs[v].frame, 1, 1);
    end

    $display("[TB] back-to-back frames");
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    release_bus(0);
    check_frame("b2b_first", 0, C_MAIN, 10'b1000000000, 0, 0);
    check_frame("b2b_second", 0, C_MAIN, 10'b1111111110, 1, 0);

    $display("[TB] FIFO full with valid held high");
    fs0       = frames_seen;
    first_cyc = 0;
    for (int e = 1; e <= 5; e++) begin
      drive_bus(0, 1'b1, 8'(e));
      #1 checkOutput($sformatf("full_ready_%0d", e), 32'(bus.tx_ready), 1);
      @(negedge clk);
      if (e == 1) first_cyc = cyc;
    end
    drive_bus(0, 1'b1, 8'h06);
    #1 checkOutput("full_ready_drop", 32'(bus.tx_ready), 0);
    waited = 0;
    while (!bus.tx_ready && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("full_ready_return_cyc", cyc, first_cyc + 1 + 10 * C_MAIN);
    @(negedge clk);
    release_bus(0);
    #1 checkOutput("full_refill", 32'(bus.tx_ready), 0);
    wait_drain("full");
    checkOutput("full_frames", frames_seen - fs0, 6);

    $display("[TB] simultaneous push and pop");
    fs0 = frames_seen;
    applyStimulus(0, 8'hA1);
    first_cyc = cyc;
    applyStimulus(0, 8'hB2);
    applyStimulus(0, 8'hC3);
    applyStimulus(0, 8'hD4);
    release_bus(0);
    while (cyc < first_cyc + 10 * C_MAIN) @(negedge clk);
    checkOutput("pp_pre_done", 32'(done), 0);
    checkOutput("pp_pre_ready", 32'(bus.tx_ready), 1);
    checkOutput("pp_pre_stop", 32'(tx), 1);
    applyStimulus(0, 8'hE5);
    release_bus(0);
    checkOutput("pp_done", 32'(done), 1);
    checkOutput("pp_new_start", 32'(tx), 0);
    checkOutput("pp_count_kept", 32'(bus.tx_ready), 1);
    applyStimulus(0, 8'hF6);
    release_bus(0);
    #1 checkOutput("pp_now_full", 32'(bus.tx_ready), 0);
    wait_drain("pp");
    checkOutput("pp_frames", frames_seen - fs0, 6);

    $display("[TB] reset mid-frame");
    fs0 = frames_seen;
    applyStimulus(0, 8'hEF);
    first_cyc = cyc;
    applyStimulus(0, 8'h22);
    applyStimulus(0, 8'h33);
    release_bus(0);
    while (cyc < first_cyc + 1 + 5 * C_MAIN + C_MAIN / 2) @(negedge clk);
    checkOutput("rst_pre_bit4", 32'(tx), 0);
    checkOutput("rst_pre_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("rst_async_tx", 32'(tx), 1);
    checkOutput("rst_async_busy", 32'(busy), 0);
    checkOutput("rst_async_ready", 32'(bus.tx_ready), 1);
    checkOutput("rst_async_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20 * C_MAIN; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput("rst_stays_idle", bad, 0);
    checkOutput("rst_no_frames", frames_seen - fs0, 0);
    applyStimulus(0, 8'h5A);
    release_bus(0);
    check_frame("rst_recover", 0, C_MAIN, 10'b1010110100, 1, 1);

    $display("[TB] random bytes against receiver model");
    fs0    = frames_seen;
    n_rand = 8;
    for (int i = 0; i < n_rand; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(0, 8'($urandom));
      release_bus(0);
    end
    wait_drain("rand");
    checkOutput("rand_frames", frames_seen - fs0, n_rand);

    $display("[TB] parameter override, 5 clocks per bit");
    applyStimulus(1, 8'h3C);
    release_bus(1);
    check_frame("p5", 1, C_P5, 10'b1001111000, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
